backtrack_ctrl: RTL and testbench
=================================

BACKTRACK_CTRL -- requirements
Module: backtrack_ctrl

Interface
REQ-001 SHALL have parameter VAR_W, default 9, width of a variable index.
REQ-002 SHALL have parameter LVL_W, default 8, width of the decision-level counter.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dec_req  input  1  solver requests a decision assignment.
REQ-006 SHALL have port imp_req  input  1  solver requests a forced (implied) assignment.
REQ-007 SHALL have port req_var / req_val  input  VAR_W / 1  variable and value for dec_req or imp_req.
REQ-008 SHALL have port conflict  input  1  solver reports a clause conflict; backtracking is requested.
REQ-009 SHALL have port ready  output  1  the controller accepts a request this cycle.
REQ-010 SHALL have ports tt_push, tt_pop  output  1 each  single-cycle command pulses to the trace table.
REQ-011 SHALL have ports tt_type / tt_val / tt_var  output  1 / 1 / VAR_W  push data; type 0 = decision, 1 = forced.
REQ-012 SHALL have ports tt_done / tt_empty  input  1 / 1  operation complete; stack holds no entries.
REQ-013 SHALL have ports tt_type_out / tt_val_out / tt_var_out  input  1 / 1 / VAR_W  popped entry, valid in the tt_done cycle after a pop.
REQ-014 SHALL have ports unassign_vld / unassign_var  output  1 / VAR_W  pulse: clear this variable in assignment memory.
REQ-015 SHALL have ports assign_vld / assign_var / assign_val  output  1 / VAR_W / 1  pulse: write the flipped assignment.
REQ-016 SHALL have ports level  output  LVL_W  current decision level.
REQ-017 SHALL have ports bt_done / unsat / ovf  output  1 each  backtrack finished (pulse); unsatisfiable (sticky); level overflow (sticky).

Function
REQ-018 SHALL implement the states IDLE, PUSH_WAIT, POP_CHK, POP_WAIT, FLIP_WAIT and UNSAT.
REQ-019 SHALL assert ready only in IDLE; requests outside IDLE SHALL be ignored, and the solver SHALL hold them.
REQ-020 SHALL arbitrate simultaneous requests in IDLE with priority conflict > imp_req > dec_req.
REQ-021 SHALL, on an accepted dec_req or imp_req, pulse tt_push for one cycle with tt_type = 0 or 1, tt_val = req_val and tt_var = req_var, then go to PUSH_WAIT.
REQ-022 SHALL, in PUSH_WAIT, go back to IDLE on tt_done; level SHALL increment in that cycle for a decision only.
REQ-023 SHALL, when a decision is accepted with level = 2^LVL_W-1, still push it, leave level unchanged and set ovf.
REQ-024 SHALL, on an accepted conflict, go to POP_CHK.
REQ-025 SHALL, in POP_CHK with tt_empty = 1, go to UNSAT and set unsat; otherwise it SHALL pulse tt_pop and go to POP_WAIT.
REQ-026 SHALL, in the POP_WAIT cycle that sees tt_done, pulse unassign_vld with unassign_var = tt_var_out.
REQ-027 SHALL, in that same cycle, go back to POP_CHK when tt_type_out = 1 (forced).
REQ-028 SHALL, in that same cycle when tt_type_out = 0 (decision):
 - pulse tt_push with type 1, value !tt_val_out, variable tt_var_out;
 - pulse assign_vld with the same variable and value;
 - decrement level (saturate at 0);
 - go to FLIP_WAIT.
REQ-029 SHALL, in FLIP_WAIT on tt_done, pulse bt_done and go to IDLE.
REQ-030 SHALL hold each command output for exactly one cycle; push data SHALL stay stable until tt_done.
REQ-031 SHALL keep UNSAT as a terminal state that ignores all requests and exits only on reset.
REQ-032 SHALL have no timeout; a trace table that never returns tt_done holds the controller in its wait state.

Reset
REQ-033 SHALL, while reset is high, force state IDLE, level = 0, clear unsat and ovf, and drive every pulse output to 0.
REQ-034 SHALL make reset override every state, including a wait state with an operation in flight; the trace table SHALL be reset on the same reset.
REQ-035 SHALL assert ready in the first cycle after reset deasserts.

Verification
REQ-036 Decision push: dec_req var=5 val=1 -> one tt_push (type 0, val 1, var 5); after tt_done, level = 1 and ready = 1.
REQ-037 Priority: conflict, imp_req and dec_req asserted together in IDLE -> no tt_push; tt_pop issued first.
REQ-038 Backtrack: stack D(3,0), F(7,1), F(9,0); conflict ->
 - unassign 9, then 7, then 3;
 - push F(3,1) and assign var 3 = 1;
 - level 1 -> 0, then bt_done.
REQ-039 UNSAT: stack holds only F(4,1); conflict -> unassign 4, tt_empty seen, unsat = 1; later dec_req gets no tt_push.
REQ-040 Overflow: LVL_W = 2 with 3 decisions pushed, then a 4th -> pushed, level stays 3, ovf = 1.
REQ-041 Reset mid-op: reset during POP_WAIT -> next cycle IDLE, level = 0, no pulses, ready = 1.

Source files
------------

// File: rtl/backtrack_ctrl.sv
// Backtracking controller for a DPLL-style solver.
// Pushes decisions and forced assignments onto an external trace table and
// tracks the decision level. On a conflict it pops entries until it reaches a
// decision, then pushes that decision back flipped as a forced assignment.
module backtrack_ctrl #(
  parameter int VAR_W = 9,
  parameter int LVL_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_req,
  input  logic             imp_req,
  input  logic [VAR_W-1:0] req_var,
  input  logic             req_val,
  input  logic             conflict,
  output logic             ready,
  output logic             tt_push,
  output logic             tt_pop,
  output logic             tt_type,
  output logic             tt_val,
  output logic [VAR_W-1:0] tt_var,
  input  logic             tt_done,
  input  logic             tt_empty,
  input  logic             tt_type_out,
  input  logic             tt_val_out,
  input  logic [VAR_W-1:0] tt_var_out,
  output logic             unassign_vld,
  output logic [VAR_W-1:0] unassign_var,
  output logic             assign_vld,
  output logic [VAR_W-1:0] assign_var,
  output logic             assign_val,
  output logic [LVL_W-1:0] level,
  output logic             bt_done,
  output logic             unsat,
  output logic             ovf
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PUSH_WAIT = 3'd1;
  localparam logic [2:0] S_POP_CHK   = 3'd2;
  localparam logic [2:0] S_POP_WAIT  = 3'd3;
  localparam logic [2:0] S_FLIP_WAIT = 3'd4;
  localparam logic [2:0] S_UNSAT     = 3'd5;

  localparam logic [LVL_W-1:0] LVL_MAX = {LVL_W{1'b1}};
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

  // Control state (reset)
  logic [2:0]       state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             unsat_q, unsat_d;
  logic             ovf_q, ovf_d;
  logic             tt_push_q, tt_push_d;
  logic             tt_pop_q, tt_pop_d;
  logic             unassign_vld_q, unassign_vld_d;
  logic             assign_vld_q, assign_vld_d;
  logic             bt_done_q, bt_done_d;

  // Data registers (qualified by the pulses above, no reset needed)
  logic             tt_type_q, tt_type_d;
  logic             tt_val_q, tt_val_d;
  logic [VAR_W-1:0] tt_var_q, tt_var_d;
  logic [VAR_W-1:0] unassign_var_q, unassign_var_d;
  logic [VAR_W-1:0] assign_var_q, assign_var_d;
  logic             assign_val_q, assign_val_d;

  // Next-state and command decode; all commands are registered single-cycle pulses
  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    unsat_d        = unsat_q;
    ovf_d          = ovf_q;
    tt_push_d      = 1'b0;
    tt_pop_d       = 1'b0;
    unassign_vld_d = 1'b0;
    assign_vld_d   = 1'b0;
    bt_done_d      = 1'b0;
    tt_type_d      = tt_type_q;
    tt_val_d       = tt_val_q;
    tt_var_d       = tt_var_q;
    unassign_var_d = unassign_var_q;
    assign_var_d   = assign_var_q;
    assign_val_d   = assign_val_q;

    case (state_q)
      S_IDLE: begin
        if (conflict) begin
          state_d = S_POP_CHK;
        end else if (imp_req || dec_req) begin
          // imp_req wins over dec_req; push data is held until tt_done
          tt_push_d = 1'b1;
          tt_type_d = imp_req;
          tt_val_d  = req_val;
          tt_var_d  = req_var;
          state_d   = S_PUSH_WAIT;
          if (!imp_req && (level_q == LVL_MAX)) ovf_d = 1'b1;
        end
      end
      S_PUSH_WAIT: begin
        if (tt_done) begin
          // A saturated level stays put; ovf was flagged at acceptance
          if (!tt_type_q && (level_q != LVL_MAX)) level_d = level_q + LVL_ONE;
          state_d = S_IDLE;
        end
      end
      S_POP_CHK: begin
        if (tt_empty) begin
          unsat_d = 1'b1;
          state_d = S_UNSAT;
        end else begin
          tt_pop_d = 1'b1;
          state_d  = S_POP_WAIT;
        end
      end
      S_POP_WAIT: begin
        if (tt_done) begin
          unassign_vld_d = 1'b1;
          unassign_var_d = tt_var_out;
          if (tt_type_out) begin
            state_d = S_POP_CHK;
          end else begin
            // Most recent decision: re-assert it flipped, now as a forced entry
            tt_push_d    = 1'b1;
            tt_type_d    = 1'b1;
            tt_val_d     = !tt_val_out;
            tt_var_d     = tt_var_out;
            assign_vld_d = 1'b1;
            assign_var_d = tt_var_out;
            assign_val_d = !tt_val_out;
            if (level_q != '0) level_d = level_q - LVL_ONE;
            state_d      = S_FLIP_WAIT;
          end
        end
      end
      S_FLIP_WAIT: begin
        if (tt_done) begin
          bt_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_UNSAT: begin
        state_d = S_UNSAT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      level_q        <= '0;
      unsat_q        <= 1'b0;
      ovf_q          <= 1'b0;
      tt_push_q      <= 1'b0;
      tt_pop_q       <= 1'b0;
      unassign_vld_q <= 1'b0;
      assign_vld_q   <= 1'b0;
      bt_done_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      unsat_q        <= unsat_d;
      ovf_q          <= ovf_d;
      tt_push_q      <= tt_push_d;
      tt_pop_q       <= tt_pop_d;
      unassign_vld_q <= unassign_vld_d;
      assign_vld_q   <= assign_vld_d;
      bt_done_q      <= bt_done_d;
    end
  end

  // Data registers
  always_ff @(posedge clk) begin
    tt_type_q      <= tt_type_d;
    tt_val_q       <= tt_val_d;
    tt_var_q       <= tt_var_d;
    unassign_var_q <= unassign_var_d;
    assign_var_q   <= assign_var_d;
    assign_val_q   <= assign_val_d;
  end

  assign ready        = (state_q == S_IDLE);
  assign tt_push      = tt_push_q;
  assign tt_pop       = tt_pop_q;
  assign tt_type      = tt_type_q;
  assign tt_val       = tt_val_q;
  assign tt_var       = tt_var_q;
  assign unassign_vld = unassign_vld_q;
  assign unassign_var = unassign_var_q;
  assign assign_vld   = assign_vld_q;
  assign assign_var   = assign_var_q;
  assign assign_val   = assign_val_q;
  assign level        = level_q;
  assign bt_done      = bt_done_q;
  assign unsat        = unsat_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Directed bench for backtrack_ctrl with a behavioural trace-table stack.
module tb_backtrack_ctrl;

  localparam int VW = 9;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dec_req = 1'b0, imp_req = 1'b0, conflict = 1'b0, req_val = 1'b0;
  logic [VW-1:0] req_var = '0;
  logic          ready, tt_push, tt_pop, tt_type, tt_val;
  logic [VW-1:0] tt_var, unassign_var, assign_var;
  logic          tt_done = 1'b0, tt_empty;
  logic          tt_type_out = 1'b0, tt_val_out = 1'b0;
  logic [VW-1:0] tt_var_out = '0;
  logic          unassign_vld, assign_vld, assign_val, bt_done, unsat, ovf;
  logic [LW-1:0] level;

  // Second instance with a 2-bit level for the overflow case
  logic          reset2 = 1'b1, dec_req2 = 1'b0;
  logic          ready2, tt_push2, tt_pop2, tt_type2, tt_val2, tt_done2 = 1'b0;
  logic [VW-1:0] tt_var2, unassign_var2, assign_var2;
  logic          unassign_vld2, assign_vld2, assign_val2, bt_done2, unsat2, ovf2;
  logic [1:0]    level2;

  int n_checks = 0;
  int n_fail   = 0;
  logic stall = 1'b0;

  always #5 clk = ~clk;

  backtrack_ctrl #(.VAR_W(VW), .LVL_W(LW)) dut (
    .clk(clk), .reset(reset), .dec_req(dec_req), .imp_req(imp_req),
    .req_var(req_var), .req_val(req_val), .conflict(conflict), .ready(ready),
    .tt_push(tt_push), .tt_pop(tt_pop), .tt_type(tt_type), .tt_val(tt_val),
    .tt_var(tt_var), .tt_done(tt_done), .tt_empty(tt_empty),
    .tt_type_out(tt_type_out), .tt_val_out(tt_val_out), .tt_var_out(tt_var_out),
    .unassign_vld(unassign_vld), .unassign_var(unassign_var),
    .assign_vld(assign_vld), .assign_var(assign_var), .assign_val(assign_val),
    .level(level), .bt_done(bt_done), .unsat(unsat), .ovf(ovf)
  );

  backtrack_ctrl #(.VAR_W(VW), .LVL_W(2)) dut2 (
    .clk(clk), .reset(reset2), .dec_req(dec_req2), .imp_req(1'b0),
    .req_var(9'd1), .req_val(1'b1), .conflict(1'b0), .ready(ready2),
    .tt_push(tt_push2), .tt_pop(tt_pop2), .tt_type(tt_type2), .tt_val(tt_val2),
    .tt_var(tt_var2), .tt_done(tt_done2), .tt_empty(1'b1),
    .tt_type_out(1'b0), .tt_val_out(1'b0), .tt_var_out(9'd0),
    .unassign_vld(unassign_vld2), .unassign_var(unassign_var2),
    .assign_vld(assign_vld2), .assign_var(assign_var2), .assign_val(assign_val2),
    .level(level2), .bt_done(bt_done2), .unsat(unsat2), .ovf(ovf2)
  );

  // Behavioural trace table: one-cycle latency stack, reset with the controller
  logic          st_type [0:63];
  logic          st_val  [0:63];
  logic [VW-1:0] st_var  [0:63];
  int sp = 0;
  assign tt_empty = (sp == 0);

  always @(posedge clk) begin
    if (reset) begin
      sp      <= 0;
      tt_done <= 1'b0;
    end else begin
      tt_done <= 1'b0;
      if (!stall && tt_push) begin
        st_type[sp] <= tt_type;
        st_val[sp]  <= tt_val;
        st_var[sp]  <= tt_var;
        sp          <= sp + 1;
        tt_done     <= 1'b1;
      end else if (!stall && tt_pop && sp > 0) begin
        tt_type_out <= st_type[sp-1];
        tt_val_out  <= st_val[sp-1];
        tt_var_out  <= st_var[sp-1];
        sp          <= sp - 1;
        tt_done     <= 1'b1;
      end
    end
  end

  // Responder for the second instance: done one cycle after any command
  always @(posedge clk) begin
    if (reset2) tt_done2 <= 1'b0;
    else        tt_done2 <= tt_push2 | tt_pop2;
  end

  // Command monitor
  int push_cnt = 0, push2_cnt = 0, u_cnt = 0, a_cnt = 0;
  logic [VW-1:0] ulog [0:63];
  logic          last_type, last_val, a_val;
  logic [VW-1:0] last_var, a_var;
  always @(posedge clk) begin
    if (tt_push) begin
      push_cnt = push_cnt + 1;
      last_type = tt_type; last_val = tt_val; last_var = tt_var;
    end
    if (tt_push2) push2_cnt = push2_cnt + 1;
    if (unassign_vld) begin
      ulog[u_cnt[5:0]] = unassign_var;
      u_cnt = u_cnt + 1;
    end
    if (assign_vld) begin
      a_cnt = a_cnt + 1;
      a_var = assign_var; a_val = assign_val;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Issue one push request and wait for the controller to return to IDLE
  task automatic do_push(input logic imp, input logic [VW-1:0] v, input logic val);
    bit ok = 0;
    imp_req = imp; dec_req = !imp; req_var = v; req_val = val;
    step();
    imp_req = 1'b0; dec_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready) begin ok = 1; break; end
      step();
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL push_timeout: ready=%b want 1", ready); end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++;
    if (level !== 8'd0 || unsat !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: level=%0d unsat=%b ovf=%b want 0/0/0", level, unsat, ovf);
    end
    n_checks++;
    if ({tt_push, tt_pop, unassign_vld, assign_vld, bt_done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 00000", {tt_push, tt_pop, unassign_vld, assign_vld, bt_done});
    end
  endtask

  task automatic test_decision();
    int p0 = push_cnt;
    bit ok = 0;
    dec_req = 1'b1; req_var = 9'd5; req_val = 1'b1;
    step();
    dec_req = 1'b0;
    n_checks++;
    if ({tt_push, tt_type, tt_val, tt_var} !== {1'b1, 1'b0, 1'b1, 9'd5}) begin
      n_fail++; $display("FAIL dec_push: push=%b type=%b val=%b var=%0d want 1/0/1/5", tt_push, tt_type, tt_val, tt_var);
    end
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL dec_busy: ready=%b want 0", ready); end
    step();
    n_checks++;
    if (tt_push !== 1'b0 || tt_var !== 9'd5) begin
      n_fail++; $display("FAIL dec_pulse_len: push=%b var=%0d want 0/5", tt_push, tt_var);
    end
    for (int i = 0; i < 20; i++) begin
      if (ready) begin ok = 1; break; end
      step();
    end
    n_checks++;
    if (!ok || level !== 8'd1) begin n_fail++; $display("FAIL dec_level: ready=%b level=%0d want 1/1", ready, level); end
    n_checks++;
    if (push_cnt - p0 !== 1) begin n_fail++; $display("FAIL dec_push_cnt: got %0d want 1", push_cnt - p0); end
  endtask

  task automatic test_forced();
    imp_req = 1'b1; req_var = 9'd6; req_val = 1'b0;
    step();
    imp_req = 1'b0;
    n_checks++;
    if ({tt_push, tt_type, tt_val, tt_var} !== {1'b1, 1'b1, 1'b0, 9'd6}) begin
      n_fail++; $display("FAIL imp_push: push=%b type=%b val=%b var=%0d want 1/1/0/6", tt_push, tt_type, tt_val, tt_var);
    end
    repeat (3) step();
    n_checks++;
    if (ready !== 1'b1 || level !== 8'd1) begin
      n_fail++; $display("FAIL imp_level: ready=%b level=%0d want 1/1", ready, level);
    end
  endtask

  task automatic test_backtrack();
    int u0, a0, p0;
    bit seen = 0;
    do_reset();
    do_push(1'b0, 9'd3, 1'b0);
    do_push(1'b1, 9'd7, 1'b1);
    do_push(1'b1, 9'd9, 1'b0);
    n_checks++;
    if (level !== 8'd1) begin n_fail++; $display("FAIL bt_pre_level: got %0d want 1", level); end
    u0 = u_cnt; a0 = a_cnt; p0 = push_cnt;
    conflict = 1'b1; imp_req = 1'b1; dec_req = 1'b1; req_var = 9'd12;
    step();
    conflict = 1'b0; imp_req = 1'b0; dec_req = 1'b0;
    n_checks++;
    if (tt_push !== 1'b0) begin n_fail++; $display("FAIL prio_no_push: push=%b want 0", tt_push); end
    step();
    n_checks++;
    if (tt_pop !== 1'b1) begin n_fail++; $display("FAIL prio_pop_first: pop=%b want 1", tt_pop); end
    for (int i = 0; i < 60; i++) begin
      if (bt_done) begin seen = 1; break; end
      step();
    end
    n_checks++;
    if (!seen || ready !== 1'b1) begin n_fail++; $display("FAIL bt_done: seen=%b ready=%b want 1/1", seen, ready); end
    n_checks++;
    if (u_cnt - u0 !== 3 || ulog[u0[5:0]] !== 9'd9 || ulog[u0[5:0]+6'd1] !== 9'd7 || ulog[u0[5:0]+6'd2] !== 9'd3) begin
      n_fail++; $display("FAIL bt_unassign: n=%0d vars=%0d,%0d,%0d want 3 9,7,3", u_cnt - u0,
                         ulog[u0[5:0]], ulog[u0[5:0]+6'd1], ulog[u0[5:0]+6'd2]);
    end
    n_checks++;
    if (a_cnt - a0 !== 1 || a_var !== 9'd3 || a_val !== 1'b1) begin
      n_fail++; $display("FAIL bt_assign: n=%0d var=%0d val=%b want 1 3 1", a_cnt - a0, a_var, a_val);
    end
    n_checks++;
    if (push_cnt - p0 !== 1 || {last_type, last_val, last_var} !== {1'b1, 1'b1, 9'd3}) begin
      n_fail++; $display("FAIL bt_flip_push: n=%0d type=%b val=%b var=%0d want 1 1/1/3", push_cnt - p0, last_type, last_val, last_var);
    end
    n_checks++;
    if (level !== 8'd0) begin n_fail++; $display("FAIL bt_level: got %0d want 0", level); end
    step();
    n_checks++;
    if (bt_done !== 1'b0) begin n_fail++; $display("FAIL bt_done_len: got %b want 0", bt_done); end
  endtask

  task automatic test_unsat();
    int u0, p0;
    bit seen = 0;
    do_reset();
    do_push(1'b1, 9'd4, 1'b1);
    u0 = u_cnt;
    conflict = 1'b1;
    step();
    conflict = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (unsat) begin seen = 1; break; end
      step();
    end
    n_checks++;
    if (!seen || ready !== 1'b0) begin n_fail++; $display("FAIL unsat_set: unsat=%b ready=%b want 1/0", unsat, ready); end
    n_checks++;
    if (u_cnt - u0 !== 1 || ulog[u0[5:0]] !== 9'd4) begin
      n_fail++; $display("FAIL unsat_unassign: n=%0d var=%0d want 1 4", u_cnt - u0, ulog[u0[5:0]]);
    end
    p0 = push_cnt;
    dec_req = 1'b1; req_var = 9'd2; req_val = 1'b0;
    repeat (5) step();
    dec_req = 1'b0;
    n_checks++;
    if (push_cnt !== p0 || unsat !== 1'b1) begin
      n_fail++; $display("FAIL unsat_terminal: pushes=%0d unsat=%b want 0/1", push_cnt - p0, unsat);
    end
  endtask

  task automatic test_overflow();
    int p0;
    reset2 = 1'b1;
    step();
    reset2 = 1'b0;
    p0 = push2_cnt;
    for (int k = 0; k < 4; k++) begin
      bit ok = 0;
      dec_req2 = 1'b1;
      step();
      dec_req2 = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (ready2) begin ok = 1; break; end
        step();
      end
      if (k == 2) begin
        n_checks++;
        if (!ok || level2 !== 2'd3 || ovf2 !== 1'b0) begin
          n_fail++; $display("FAIL ovf_pre: ready=%b level=%0d ovf=%b want 1/3/0", ready2, level2, ovf2);
        end
      end
    end
    n_checks++;
    if (level2 !== 2'd3 || ovf2 !== 1'b1 || ready2 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: level=%0d ovf=%b ready=%b want 3/1/1", level2, ovf2, ready2);
    end
    n_checks++;
    if (push2_cnt - p0 !== 4) begin n_fail++; $display("FAIL ovf_pushes: got %0d want 4", push2_cnt - p0); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    do_push(1'b0, 9'd8, 1'b1);
    stall = 1'b1;
    conflict = 1'b1;
    step();
    conflict = 1'b0;
    repeat (4) step();
    n_checks++;
    if (ready !== 1'b0 || level !== 8'd1) begin
      n_fail++; $display("FAIL midop_stuck: ready=%b level=%0d want 0/1", ready, level);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    stall = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || level !== 8'd0) begin
      n_fail++; $display("FAIL midop_reset: ready=%b level=%0d want 1/0", ready, level);
    end
    step();
    n_checks++;
    if (ready !== 1'b1 || {tt_push, tt_pop, unassign_vld, assign_vld, bt_done} !== 5'b0) begin
      n_fail++; $display("FAIL midop_after: ready=%b pulses=%b want 1/00000", ready,
                         {tt_push, tt_pop, unassign_vld, assign_vld, bt_done});
    end
  endtask

  initial begin
    test_reset();
    test_decision();
    test_forced();
    test_backtrack();
    test_unsat();
    test_overflow();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
